reg_write_sequencer: RTL and testbench

- Writer-side counterpart of the 4-bit load-enabled registers.
- Accepts a write request (target register select plus 4-bit value) over a ready/valid handshake.
- Drives the shared data bus, then pulses exactly one active-low load line for exactly one clock edge.
- Sits between the control unit and the register bank, guaranteeing data setup before the capture edge and hold after it.

---
 rtl/reg_write_sequencer.sv | 152 +++++++++++++++
 tb/tb_reg_write_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_sequencer.sv
// reg_write_sequencer: drives one write into a bank of 4-bit load-enabled registers (setup, strobe, hold).
// Defining REG_WRITE_READBACK_EN adds a CHECK state that verifies the written value via rb_data.
module reg_write_sequencer #(
   parameter int unsigned NREGS        = 4,
   parameter int unsigned SELW         = 2,
   parameter int unsigned SETUP_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req,
   input  logic [SELW-1:0]      sel,
   input  logic [3:0]           data_in,
   output logic                 ready,
   output logic [3:0]           data_out,
   output logic [NREGS-1:0]     load_n,
   output logic                 done,
   output logic                 err,
   input  logic [4*NREGS-1:0]   rb_data
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_STROBE = 3'd2;
   localparam logic [2:0] S_HOLD   = 3'd3;
`ifdef REG_WRITE_READBACK_EN
   localparam logic [2:0] S_CHECK  = 3'd4;
`endif
   localparam logic [3:0] SETUP_LOAD = 4'(SETUP_CYCLES);

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;
   logic [3:0]       r_cnt;
   logic [3:0]       w_cnt_nxt;
   logic [SELW-1:0]  r_sel;
   logic             r_oor;
   logic [3:0]       r_data_out;
   logic [NREGS-1:0] r_load_n;
   logic [NREGS-1:0] w_load_n_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic             w_ready;
   logic             w_accept;
   logic             w_sel_oor;

   // A shift past the vector width yields zero, so out-of-range selects decode to no strobe.
   function automatic logic [NREGS-1:0] decode_strobe(input logic [SELW-1:0] s);
      return ~(NREGS'(1) << s);
   endfunction

   assign w_ready   = (r_state == S_IDLE) && !reset;
   assign w_accept  = req && w_ready;
   assign w_sel_oor = (32'(sel) >= NREGS);

`ifdef REG_WRITE_READBACK_EN
   logic [3:0] w_rb_word;
   logic       w_mismatch;

   assign w_rb_word  = 4'(rb_data >> {r_sel, 2'b00});
   assign w_mismatch = (w_rb_word != r_data_out);
`else
   logic w_unused_rb;
   assign w_unused_rb = ^rb_data;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_load_n_nxt = '1;
      w_done_nxt   = 1'b0;
      w_err_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (SETUP_LOAD == 4'd0) begin
                  // No setup phase: strobe comes straight from the incoming select.
                  w_state_nxt  = S_STROBE;
                  w_load_n_nxt = decode_strobe(sel);
               end else begin
                  w_state_nxt = S_SETUP;
                  w_cnt_nxt   = SETUP_LOAD;
               end
            end
         end
         S_SETUP: begin
            if (r_cnt <= 4'd1) begin
               w_state_nxt  = S_STROBE;
               w_cnt_nxt    = '0;
               w_load_n_nxt = decode_strobe(r_sel);
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_STROBE: begin
            w_state_nxt = S_HOLD;
`ifndef REG_WRITE_READBACK_EN
            w_done_nxt  = 1'b1;
            w_err_nxt   = r_oor;
`endif
         end
         S_HOLD: begin
`ifdef REG_WRITE_READBACK_EN
            w_state_nxt = S_CHECK;
            w_done_nxt  = 1'b1;
            w_err_nxt   = r_oor || w_mismatch;
`else
            w_state_nxt = S_IDLE;
`endif
         end
`ifdef REG_WRITE_READBACK_EN
         S_CHECK: begin
            w_state_nxt = S_IDLE;
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_sel      <= '0;
         r_oor      <= 1'b0;
         r_data_out <= '0;
         r_load_n   <= '1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_load_n <= w_load_n_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
         if (w_accept) begin
            r_sel      <= sel;
            r_oor      <= w_sel_oor;
            r_data_out <= data_in;
         end
      end
   end

   assign ready    = w_ready;
   assign data_out = r_data_out;
   assign load_n   = r_load_n;
   assign done     = r_done;
   assign err      = r_err;

endmodule

// File: tb/tb_reg_write_sequencer.sv
// Bench for reg_write_sequencer: instance a (4 regs, 1 setup cycle) and instance b (3 regs, zero setup),
// with a register-bank model feeding rb_data and a queue scoreboard checking strobe and done timing.
module tb_reg_write_sequencer;

`ifdef REG_WRITE_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        a_req, b_req;
   logic [1:0]  a_sel, b_sel;
   logic [3:0]  a_din, b_din;
   logic        a_ready, b_ready;
   logic [3:0]  a_dout, b_dout;
   logic [3:0]  a_load_n;
   logic [2:0]  b_load_n;
   logic        a_done, b_done, a_err, b_err;
   logic [15:0] a_rb;
   logic [11:0] b_rb;
   logic        a_stuck;

   logic        rdy [2];
   logic [3:0]  ln  [2];
   logic [3:0]  dout[2];
   logic        dn  [2];
   logic        er  [2];

   logic [3:0]  mreg [2][4] = '{default: 4'h0};
   int          cyc = 0;
   int          n_checks = 0;
   int          n_errors = 0;

   typedef struct {
      int         d;
      int         sel;
      logic [3:0] data;
      bit         err;
      int         acc;
      int         nstb;
   } exp_t;
   exp_t q[$];

   typedef struct {
      int         d;
      logic [1:0] sel;
      logic [3:0] data;
      bit         err;
   } vec_t;
   vec_t vecs[8];

   reg_write_sequencer #(.NREGS(4), .SELW(2), .SETUP_CYCLES(1)) u_a (
      .clk(clk), .reset(reset), .req(a_req), .sel(a_sel), .data_in(a_din),
      .ready(a_ready), .data_out(a_dout), .load_n(a_load_n), .done(a_done),
      .err(a_err), .rb_data(a_rb)
   );

   reg_write_sequencer #(.NREGS(3), .SELW(2), .SETUP_CYCLES(0)) u_b (
      .clk(clk), .reset(reset), .req(b_req), .sel(b_sel), .data_in(b_din),
      .ready(b_ready), .data_out(b_dout), .load_n(b_load_n), .done(b_done),
      .err(b_err), .rb_data(b_rb)
   );

   assign rdy[0]  = a_ready;
   assign rdy[1]  = b_ready;
   assign ln[0]   = a_load_n;
   assign ln[1]   = {1'b1, b_load_n};
   assign dout[0] = a_dout;
   assign dout[1] = b_dout;
   assign dn[0]   = a_done;
   assign dn[1]   = b_done;
   assign er[0]   = a_err;
   assign er[1]   = b_err;

   // Register 1 of bank a can be forced to read back as zero.
   assign a_rb = {mreg[0][3], mreg[0][2], a_stuck ? 4'h0 : mreg[0][1], mreg[0][0]};
   assign b_rb = {mreg[1][2], mreg[1][1], mreg[1][0]};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (!ln[0][i]) mreg[0][i] <= dout[0];
         if (!ln[1][i]) mreg[1][i] <= dout[1];
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 200000");
      $fatal(1, "global timeout");
   end

   function automatic int nreg(input int d);
      return (d == 0) ? 4 : 3;
   endfunction

   function automatic int sdly(input int d);
      return (d == 0) ? 1 : 0;
   endfunction

   function automatic int find(input int d);
      foreach (q[i]) if (q[i].d == d) return i;
      return -1;
   endfunction

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic mon_step(input int d);
      int         idx;
      int         sel;
      int         lat;
      bit         oor;
      logic [3:0] exp_ln;
      idx = find(d);
      chk(rdy[d] == (idx < 0), "ready", rdy[d], idx < 0);
      chk($countones(~ln[d]) <= 1, "single_strobe", $countones(~ln[d]), 1);
      if (ln[d] != 4'hF) begin
         chk(idx >= 0, "strobe_expected", ln[d], 4'hF);
         if (idx >= 0) begin
            sel    = q[idx].sel;
            oor    = sel >= nreg(d);
            exp_ln = oor ? 4'hF : ~(4'b0001 << sel);
            chk(ln[d] == exp_ln, "strobe_pattern", ln[d], exp_ln);
            chk(cyc - q[idx].acc == sdly(d) + 1, "strobe_latency", cyc - q[idx].acc, sdly(d) + 1);
            chk(dout[d] == q[idx].data, "strobe_data", dout[d], q[idx].data);
            q[idx].nstb = q[idx].nstb + 1;
         end
      end
      if (dn[d]) begin
         chk(idx >= 0, "done_expected", dn[d], 0);
         if (idx >= 0) begin
            sel = q[idx].sel;
            oor = sel >= nreg(d);
            lat = cyc - q[idx].acc;
            chk(lat == sdly(d) + 2 + int'(RB), "done_latency", lat, sdly(d) + 2 + int'(RB));
            chk(er[d] == q[idx].err, "err", er[d], q[idx].err);
            chk(q[idx].nstb == (oor ? 0 : 1), "strobe_count", q[idx].nstb, oor ? 0 : 1);
            chk(dout[d] == q[idx].data, "done_data", dout[d], q[idx].data);
            if (!oor) chk(mreg[d][sel] == q[idx].data, "reg_model", mreg[d][sel], q[idx].data);
            q.delete(idx);
         end
      end else begin
         chk(!er[d], "err_without_done", er[d], 0);
      end
   endtask

   task automatic set_req(input int d, input logic r, input logic [1:0] s, input logic [3:0] v);
      if (d == 0) begin
         a_req = r; a_sel = s; a_din = v;
      end else begin
         b_req = r; b_sel = s; b_din = v;
      end
   endtask

   // Holds req until the DUT is ready; the expectation is queued at the accepting cycle.
   task automatic write(input int d, input logic [1:0] s, input logic [3:0] v, input bit e,
                        input bit now, output int acc);
      bit   got;
      exp_t x;
      got = 1'b0;
      acc = -1;
      if (!now) begin
         @(negedge clk); #2;
      end
      set_req(d, 1'b1, s, v);
      for (int i = 0; i < 64 && !got; i++) begin
         if (rdy[d]) begin
            got    = 1'b1;
            acc    = cyc;
            x.d    = d;
            x.sel  = int'(s);
            x.data = v;
            x.err  = e;
            x.acc  = cyc;
            x.nstb = 0;
            q.push_back(x);
         end
         @(negedge clk); #2;
      end
      set_req(d, 1'b0, 2'd0, 4'h0);
      chk(got, "accept_timeout", got, 1);
      if (got) chk(dout[d] == v, "data_out_after_accept", dout[d], v);
   endtask

   task automatic wait_idle(input int d);
      for (int i = 0; i < 100; i++) begin
         if (find(d) < 0) break;
         @(negedge clk); #2;
      end
      chk(find(d) < 0, "done_timeout", find(d), -1);
   endtask

   initial begin
      int         acc1;
      int         acc2;
      logic [3:0] old;

      vecs[0] = '{0, 2'd2, 4'hA, 1'b0};
      vecs[1] = '{0, 2'd0, 4'h5, 1'b0};
      vecs[2] = '{0, 2'd3, 4'hF, 1'b0};
      vecs[3] = '{0, 2'd1, 4'hC, 1'b0};
      vecs[4] = '{1, 2'd0, 4'h5, 1'b0};
      vecs[5] = '{1, 2'd3, 4'h9, 1'b1};
      vecs[6] = '{1, 2'd2, 4'h7, 1'b0};
      vecs[7] = '{1, 2'd1, 4'h3, 1'b0};

      reset   = 1'b1;
      a_stuck = 1'b0;
      set_req(0, 1'b0, 2'd0, 4'h0);
      set_req(1, 1'b0, 2'd0, 4'h0);
      #6;
      for (int d = 0; d < 2; d++) begin
         chk(ln[d] == 4'hF, "reset_load_n", ln[d], 4'hF);
         chk(dout[d] == 4'h0, "reset_data_out", dout[d], 0);
         chk(!dn[d], "reset_done", dn[d], 0);
         chk(!er[d], "reset_err", er[d], 0);
         chk(!rdy[d], "reset_ready", rdy[d], 0);
      end

      fork
         forever begin
            @(negedge clk);
            if (!reset) begin
               mon_step(0);
               mon_step(1);
            end
         end
      join_none

      @(negedge clk); #2;
      reset = 1'b0;
      #1;
      chk(rdy[0], "ready_after_reset_a", rdy[0], 1);
      chk(rdy[1], "ready_after_reset_b", rdy[1], 1);

      for (int i = 0; i < 8; i++) begin
         write(vecs[i].d, vecs[i].sel, vecs[i].data, vecs[i].err, 1'b0, acc1);
         wait_idle(vecs[i].d);
      end

      // Second request is raised while the first is still in SETUP and must wait.
      write(0, 2'd1, 4'h2, 1'b0, 1'b0, acc1);
      write(0, 2'd3, 4'hF, 1'b0, 1'b1, acc2);
      chk(acc2 - acc1 == sdly(0) + 3 + int'(RB), "throughput", acc2 - acc1, sdly(0) + 3 + int'(RB));
      wait_idle(0);
      repeat (3) @(negedge clk);
      #2;
      chk(dout[0] == 4'hF, "idle_data_hold", dout[0], 4'hF);

      a_stuck = 1'b1;
      write(0, 2'd1, 4'h6, RB, 1'b0, acc1);
      wait_idle(0);
      a_stuck = 1'b0;
      write(0, 2'd1, 4'h6, 1'b0, 1'b0, acc1);
      wait_idle(0);

      old = mreg[0][1];
      write(0, 2'd1, 4'h3, 1'b0, 1'b0, acc1);
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      chk(ln[0] == 4'hF, "midop_reset_load_n", ln[0], 4'hF);
      chk(dout[0] == 4'h0, "midop_reset_data_out", dout[0], 0);
      chk(!dn[0], "midop_reset_done", dn[0], 0);
      chk(!rdy[0], "midop_reset_ready", rdy[0], 0);
      q.delete();
      @(negedge clk); #2;
      reset = 1'b0;
      #1;
      chk(rdy[0], "midop_ready_after_release", rdy[0], 1);
      repeat (6) @(negedge clk);
      #2;
      chk(mreg[0][1] == old, "midop_no_capture", mreg[0][1], old);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
